branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Consumer side of the ALU result/condition-code interface for the 16-bit SIMPLE-style core.
- Latches the 4-bit condition code {S,Z,C,V} into a flag register on ALU-class instructions.
- Evaluates the B/BE/BLT/BLE/BNE conditions against that register and owns the 12-bit PC: increment, redirect, flush bubble and halt.
- Sits between the execute stage (ALU outputs) and instruction fetch.

Parameters:
- PC_W, 12, PC / branch-target width.
- RESET_PC, 12'h000, PC value after reset and after restart.
- FLUSH_CYCLES, 1, bubble cycles asserted after a taken branch (range 1-3).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage holds a valid instruction this cycle
- ex_instr  in  16  instruction in execute
- alu_code  in  4  ALU condition code {S,Z,C,V}, valid with ex_valid
- alu_x  in  16  ALU result; bits [PC_W-1:0] are the branch target for branch instructions
- stall  in  1  pipeline stall; freezes PC, flags and state
- restart  in  1  single-cycle pulse; leaves HALT
- pc  out  PC_W  fetch address
- flags  out  4  flag register {S,Z,C,V}
- flush  out  1  squash the fetch/decode instruction(s)
- taken  out  1  single-cycle pulse on a taken branch
- halted  out  1  high while in HALT
- br_taken_cnt  out  16  taken-branch counter (feature-gated)
- br_total_cnt  out  16  executed-branch counter (feature-gated)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, flags=4'b0000, flush=0, taken=0, halted=0, counters=0, state=RUN.
  - Reset mid-FLUSH or mid-HALT returns to RUN immediately.
- Instruction classes:
  - ALU: ex_instr[15:14]=2'b11 with op3=ex_instr[7:4] in {0000,0001,0010,0011,0100,0101,1000}.
  - HLT: ex_instr[15:14]=2'b11 with op3=1111.
  - B: ex_instr[15:11]=5'b10100.
  - Bcc: ex_instr[15:11]=5'b10111, cond=ex_instr[10:8].
- Flags: on ex_valid & ALU & !stall & state=RUN, flags<=alu_code at the clock edge. All other instructions leave flags unchanged.
- Conditions, evaluated on the registered flags, never on the same-cycle alu_code:
  - B always taken.
  - 000 BE: Z.
  - 001 BLT: S^V.
  - 010 BLE: Z|(S^V).
  - 011 BNE: !Z.
  - 100-111: never taken; treated as a not-taken branch.
- States:
  - RUN: if stall, hold everything. Else:
    - Taken branch: pc<=alu_x[PC_W-1:0], taken=1 for one cycle, go to FLUSH with counter FLUSH_CYCLES-1.
    - HLT: go to HALT, pc holds.
    - Otherwise: pc<=pc+1, wrapping 12'hFFF->12'h000.
  - FLUSH: flush=1 every cycle in this state; pc increments normally from the target. Exit to RUN when the counter reaches 0; stall holds the counter. ex_valid is ignored in FLUSH (squashed instruction), so no flag update and no branch.
  - HALT: halted=1, pc frozen, ex_valid ignored. restart=1 -> pc<=RESET_PC, RUN. restart is ignored in RUN/FLUSH.
- Registered outputs; total latency = 1 cycle from a taken branch in execute to the new pc.
- Simultaneous stall and restart in HALT: restart wins; HALT does not honour stall.

Optional Feature:
- BRANCH_STATS_EN defined:
  - br_total_cnt increments on every B/Bcc accepted in RUN.
  - br_taken_cnt increments on taken ones.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package/header, shared with the ALU:
  - Opcode constants: F_ADD..F_MOV, F_HLT=4'b1111, OP_B=5'b10100, OP_BCC=5'b10111.
  - Condition codes: C_BE/C_BLT/C_BLE/C_BNE.
  - Flag bit indices: S=3, Z=2, C=1, V=0.
  - State encoding: RUN/FLUSH/HALT.
- One sub-module: cond_eval, combinational (flags, instr) -> is_branch, take.

Test Plan:
- Reset release then 5 unstalled cycles with ex_valid=0 -> pc goes 000,001,...,005; flags=0000; flush=0.
- ALU CMP with alu_code=0100, next cycle BE with alu_x=16'h0040 -> taken pulse; pc=040; flush=1 for exactly FLUSH_CYCLES cycles; flags stay 0100.
- flags=1000 (S=1,V=0): BLT taken; BLE taken; BNE taken; BE not taken -> pc=pc+1; cond 101 not taken.
- pc=FFF, no branch -> pc wraps to 000; stall held 3 cycles in RUN and in FLUSH -> pc, flags and flush counter unchanged.
- HLT at pc=010 -> halted=1, pc stays 010 for 10 cycles despite ex_valid; restart pulse -> pc=RESET_PC, halted=0. rst_n pulsed low mid-FLUSH -> outputs return to reset values asynchronously.
- With BRANCH_STATS_EN: 3 taken + 2 not-taken branches -> br_total_cnt=5, br_taken_cnt=3. Without the macro -> both read 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared opcode, condition-code, flag-index and state definitions for the
// execute-stage ALU and the branch controller.
package branch_ctrl_pkg;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_XOR = 4'b0100;
  localparam logic [3:0] F_CMP = 4'b0101;
  localparam logic [3:0] F_MOV = 4'b1000;
  localparam logic [3:0] F_HLT = 4'b1111;

  localparam logic [4:0] OP_B   = 5'b10100;
  localparam logic [4:0] OP_BCC = 5'b10111;

  localparam logic [2:0] C_BE  = 3'b000;
  localparam logic [2:0] C_BLT = 3'b001;
  localparam logic [2:0] C_BLE = 3'b010;
  localparam logic [2:0] C_BNE = 3'b011;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StHalt  = 2'd2
  } state_e;

  function automatic logic is_alu(input logic [15:0] instr);
    return (instr[15:14] == 2'b11) &&
           (instr[7:4] inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_CMP, F_MOV});
  endfunction

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:14] == 2'b11) && (instr[7:4] == F_HLT);
  endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational branch decode: flags the B/Bcc class and decides whether the
// branch is taken against the registered flags.
module branch_ctrl_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [3:0]  flags,
  input  logic [15:0] instr,
  output logic        is_branch,
  output logic        take
);

  logic s_xor_v;
  logic unused_bits;

  assign s_xor_v     = flags[FLAG_S] ^ flags[FLAG_V];
  assign unused_bits = ^{instr[7:0], flags[FLAG_C]};

  always_comb begin
    is_branch = 1'b0;
    take      = 1'b0;
    if (instr[15:11] == OP_B) begin
      is_branch = 1'b1;
      take      = 1'b1;
    end else if (instr[15:11] == OP_BCC) begin
      is_branch = 1'b1;
      // Reserved condition codes decode as a branch that is never taken.
      case (instr[10:8])
        C_BE:    take = flags[FLAG_Z];
        C_BLT:   take = s_xor_v;
        C_BLE:   take = flags[FLAG_Z] | s_xor_v;
        C_BNE:   take = ~flags[FLAG_Z];
        default: take = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/PC controller: latches ALU flags, resolves branches and owns the fetch PC.
// Define BRANCH_STATS_EN to build the saturating taken/total branch counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W         = 12,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [15:0]     ex_instr,
  input  logic [3:0]      alu_code,
  input  logic [15:0]     alu_x,
  input  logic            stall,
  input  logic            restart,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            flush,
  output logic            taken,
  output logic            halted,
  output logic [15:0]     br_taken_cnt,
  output logic [15:0]     br_total_cnt
);

  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            taken_q, taken_d;
  logic            is_branch, take;
  logic            accept, br_taken, hlt_acc;
  logic            unused_alu_x;

  assign unused_alu_x = ^alu_x[15:PC_W];

  branch_ctrl_cond_eval u_cond_eval (
    .flags     (flags_q),
    .instr     (ex_instr),
    .is_branch (is_branch),
    .take      (take)
  );

  // Only RUN acts on the execute instruction; FLUSH squashes it and HALT ignores it.
  assign accept   = (state_q == StRun) && !stall && ex_valid;
  assign br_taken = accept && is_branch && take;
  assign hlt_acc  = accept && is_hlt(ex_instr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      flags_q <= 4'b0000;
      cnt_q   <= 2'd0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    taken_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (br_taken) begin
            state_d = StFlush;
            cnt_d   = FlushInit;
            pc_d    = alu_x[PC_W-1:0];
            taken_d = 1'b1;
          end else if (hlt_acc) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
          end
          if (accept && is_alu(ex_instr)) flags_d = alu_code;
        end
      end
      StFlush: begin
        if (!stall) begin
          pc_d = pc_q + 1'b1;
          if (cnt_q == 2'd0) state_d = StRun;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      StHalt: begin
        // restart has priority over stall here
        if (restart) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc     = pc_q;
    flags  = flags_q;
    taken  = taken_q;
    flush  = (state_q == StFlush);
    halted = (state_q == StHalt);
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, total_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 16'h0000;
      total_cnt_q <= 16'h0000;
    end else if (accept && is_branch) begin
      if (total_cnt_q != 16'hFFFF)             total_cnt_q <= total_cnt_q + 16'h0001;
      if (take && (taken_cnt_q != 16'hFFFF))   taken_cnt_q <= taken_cnt_q + 16'h0001;
    end
  end

  assign br_taken_cnt = taken_cnt_q;
  assign br_total_cnt = total_cnt_q;
`else
  assign br_taken_cnt = 16'h0000;
  assign br_total_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// instruction streams compared against a behavioural model of PC/flag/branch rules.
module tb_branch_ctrl;

  localparam int unsigned PC_W         = 12;
  localparam int unsigned FLUSH_CYCLES = 1;
  localparam logic [11:0] RESET_PC     = 12'h000;
`ifdef BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_instr = 16'h0000;
  logic [3:0]  alu_code = 4'h0;
  logic [15:0] alu_x = 16'h0000;
  logic        stall = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] pc;
  logic [3:0]  flags;
  logic        flush, taken, halted;
  logic [15:0] br_taken_cnt, br_total_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [11:0] m_pc;
  logic [3:0]  m_flags;
  int          m_flush_left;
  bit          m_halted, m_taken;
  int          m_total, m_taken_n;

  always #5 clk = ~clk;

  branch_ctrl #(
    .PC_W         (PC_W),
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_instr     (ex_instr),
    .alu_code     (alu_code),
    .alu_x        (alu_x),
    .stall        (stall),
    .restart      (restart),
    .pc           (pc),
    .flags        (flags),
    .flush        (flush),
    .taken        (taken),
    .halted       (halted),
    .br_taken_cnt (br_taken_cnt),
    .br_total_cnt (br_total_cnt)
  );

  function automatic logic [15:0] alu_i(input logic [3:0] op);
    return {2'b11, 6'b000000, op, 4'b0000};
  endfunction

  function automatic logic [15:0] bcc_i(input logic [2:0] cond);
    return {5'b10111, cond, 8'h00};
  endfunction

  localparam logic [15:0] B_I   = 16'hA000;
  localparam logic [15:0] HLT_I = 16'hC0F0;

  function automatic bit m_is_alu(input logic [15:0] ins);
    logic [3:0] op = ins[7:4];
    return (ins[15:14] == 2'b11) && ((op <= 4'd5) || (op == 4'd8));
  endfunction

  // -1: not a branch, 0: branch not taken, 1: branch taken
  function automatic int br_outcome(input logic [15:0] ins, input logic [3:0] f);
    bit s = f[3];
    bit z = f[2];
    bit v = f[0];
    if (ins[15:11] == 5'b10100) return 1;
    if (ins[15:11] != 5'b10111) return -1;
    case (ins[10:8])
      3'd0:    return z ? 1 : 0;
      3'd1:    return (s != v) ? 1 : 0;
      3'd2:    return (z || (s != v)) ? 1 : 0;
      3'd3:    return z ? 0 : 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] exp_total();
    return STATS_EN ? 16'(m_total) : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_taken_n();
    return STATS_EN ? 16'(m_taken_n) : 16'h0000;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_flags = 4'h0; m_flush_left = 0;
    m_halted = 0; m_taken = 0; m_total = 0; m_taken_n = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic cycle(input bit v, input logic [15:0] ins, input logic [3:0] code,
                       input logic [15:0] x, input bit st, input bit rs);
    int o;
    ex_valid = v; ex_instr = ins; alu_code = code; alu_x = x; stall = st; restart = rs;
    o = br_outcome(ins, m_flags);
    m_taken = 0;
    if (m_halted) begin
      if (rs) begin m_halted = 0; m_pc = RESET_PC; end
    end else if (m_flush_left > 0) begin
      if (!st) begin m_pc++; m_flush_left--; end
    end else if (!st) begin
      if (v && m_is_alu(ins)) begin
        m_flags = code; m_pc++;
      end else if (v && o >= 0) begin
        if (m_total < 65535) m_total++;
        if (o == 1) begin
          m_pc = x[11:0]; m_taken = 1; m_flush_left = FLUSH_CYCLES;
          if (m_taken_n < 65535) m_taken_n++;
        end else m_pc++;
      end else if (v && ins[15:14] == 2'b11 && ins[7:4] == 4'hF) begin
        m_halted = 1;
      end else m_pc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 16'h0000, 4'h0, 16'h0000, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, RESET_PC); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h exp 0", flags); end
    checks++; if ({flush, taken, halted} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b exp 000", {flush, taken, halted}); end
    checks++; if ({br_taken_cnt, br_total_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h exp 0/0", br_taken_cnt, br_total_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      checks++; if (pc !== 12'(i)) begin errors++; $display("FAIL count_pc %0d: got %h exp %h", i, pc, 12'(i)); end
      checks++; if ({flags, flush} !== 5'b0) begin errors++; $display("FAIL count_flags_flush %0d: got %h/%b exp 0/0", i, flags, flush); end
    end
  endtask

  task automatic test_branch_be();
    cycle(1, alu_i(4'b0101), 4'b0100, 16'h1234, 0, 0);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL be_flags: got %b exp 0100", flags); end
    cycle(1, bcc_i(3'b000), 4'b1111, 16'h0040, 0, 0);
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL be_taken: got %b exp 1", taken); end
    checks++; if (pc !== 12'h040) begin errors++; $display("FAIL be_pc: got %h exp 040", pc); end
    for (int i = 0; i < int'(FLUSH_CYCLES); i++) begin
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL be_flush %0d: got %b exp 1", i, flush); end
      // squashed instructions must not update flags or redirect
      cycle(1, (i % 2 == 0) ? B_I : alu_i(4'b0000), 4'b1011, 16'h0123, 0, 0);
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL be_taken_pulse %0d: got %b exp 0", i, taken); end
    end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL be_flush_end: got %b exp 0", flush); end
    checks++; if (pc !== 12'(12'h040 + FLUSH_CYCLES)) begin errors++; $display("FAIL be_pc_after: got %h exp %h", pc, 12'(12'h040 + FLUSH_CYCLES)); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL be_flags_hold: got %b exp 0100", flags); end
  endtask

  task automatic test_conditions();
    logic [2:0]  conds [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd5};
    bit          exp_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] start, tgt;
    cycle(1, alu_i(4'b0001), 4'b1000, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      start = pc;
      tgt = 12'($urandom_range(16'h100, 16'hE00));
      cycle(1, bcc_i(conds[i]), 4'b0111, {4'h0, tgt}, 0, 0);
      checks++; if (taken !== exp_t[i]) begin errors++; $display("FAIL cond_%0d_taken: got %b exp %b", conds[i], taken, exp_t[i]); end
      checks++;
      if (pc !== (exp_t[i] ? tgt : 12'(start + 12'd1))) begin
        errors++; $display("FAIL cond_%0d_pc: got %h exp %h", conds[i], pc, exp_t[i] ? tgt : 12'(start + 12'd1));
      end
      if (exp_t[i]) idle(FLUSH_CYCLES);
    end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL cond_flags: got %b exp 1000", flags); end
  endtask

  task automatic test_wrap_stall();
    logic [11:0] p;
    logic [3:0]  f;
    cycle(1, B_I, 4'h0, 16'h0FF0, 0, 0);
    for (int i = 0; i < 40 && m_pc != 12'hFFF; i++) idle(1);
    checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_pre: got %h exp fff", pc); end
    idle(1);
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got %h exp 000", pc); end
    p = pc; f = flags;
    for (int i = 0; i < 3; i++) begin
      cycle(1, (i == 0) ? B_I : alu_i(4'b0010), 4'b1111, 16'h0777, 1, 0);
      checks++; if ({pc, flags, taken} !== {p, f, 1'b0}) begin errors++; $display("FAIL stall_run %0d: got %h/%b/%b exp %h/%b/0", i, pc, flags, taken, p, f); end
    end
    cycle(1, B_I, 4'h0, 16'h0200, 0, 0);
    p = pc;
    for (int i = 0; i < 3; i++) begin
      cycle(1, B_I, 4'hF, 16'h0555, 1, 0);
      checks++; if ({pc, flush} !== {p, 1'b1}) begin errors++; $display("FAIL stall_flush %0d: got %h/%b exp %h/1", i, pc, flush, p); end
    end
    for (int i = 0; i < int'(FLUSH_CYCLES); i++) begin
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_flush_resume %0d: got %b exp 1", i, flush); end
      idle(1);
    end
    checks++; if ({pc, flush} !== {12'(p + FLUSH_CYCLES), 1'b0}) begin errors++; $display("FAIL stall_flush_exit: got %h/%b exp %h/0", pc, flush, 12'(p + FLUSH_CYCLES)); end
  endtask

  task automatic test_halt();
    cycle(1, B_I, 4'h0, 16'(12'h010 - FLUSH_CYCLES), 0, 0);
    idle(FLUSH_CYCLES);
    checks++; if (pc !== 12'h010) begin errors++; $display("FAIL halt_pre_pc: got %h exp 010", pc); end
    cycle(1, HLT_I, 4'h0, 16'h0000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checks++; if ({pc, halted} !== {12'h010, 1'b1}) begin errors++; $display("FAIL halt_hold %0d: got %h/%b exp 010/1", i, pc, halted); end
      cycle(1, (i % 2 == 0) ? B_I : alu_i(4'b0000), 4'hF, 16'h0300, $urandom_range(0, 1), 0);
    end
    cycle(0, 16'h0000, 4'h0, 16'h0000, 1, 1);
    checks++; if ({pc, halted} !== {RESET_PC, 1'b0}) begin errors++; $display("FAIL halt_restart: got %h/%b exp %h/0", pc, halted, RESET_PC); end
    cycle(0, 16'h0000, 4'h0, 16'h0000, 0, 1);
    checks++; if ({pc, halted} !== {12'(RESET_PC + 12'd1), 1'b0}) begin errors++; $display("FAIL restart_in_run: got %h/%b exp %h/0", pc, halted, 12'(RESET_PC + 12'd1)); end
  endtask

  task automatic test_async_reset();
    cycle(1, B_I, 4'h0, 16'h0300, 0, 0);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL areset_pre_flush: got %b exp 1", flush); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({pc, flags} !== {RESET_PC, 4'h0}) begin errors++; $display("FAIL areset_pc_flags: got %h/%h exp %h/0", pc, flags, RESET_PC); end
    checks++; if ({flush, taken, halted} !== 3'b000) begin errors++; $display("FAIL areset_ctl: got %b exp 000", {flush, taken, halted}); end
    checks++; if ({br_taken_cnt, br_total_cnt} !== 32'h0) begin errors++; $display("FAIL areset_cnt: got %h/%h exp 0/0", br_taken_cnt, br_total_cnt); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stats();
    for (int i = 0; i < 3; i++) begin
      cycle(1, B_I, 4'h0, 16'(16'h0100 * (i + 1)), 0, 0);
      idle(FLUSH_CYCLES);
    end
    cycle(1, bcc_i(3'd5), 4'h0, 16'h0999, 0, 0);
    cycle(1, bcc_i(3'd6), 4'h0, 16'h0999, 0, 0);
    checks++; if (br_total_cnt !== (STATS_EN ? 16'd5 : 16'd0)) begin errors++; $display("FAIL stats_total: got %0d exp %0d", br_total_cnt, STATS_EN ? 5 : 0); end
    checks++; if (br_taken_cnt !== (STATS_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stats_taken: got %0d exp %0d", br_taken_cnt, STATS_EN ? 3 : 0); end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
    case ($urandom_range(0, 9))
      0, 1, 2: return {2'b11, 6'($urandom), ops[$urandom_range(0, 6)], 4'($urandom)};
      3, 4:    return {5'b10100, 11'($urandom)};
      5, 6, 7: return {5'b10111, 11'($urandom)};
      8:       return {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) < 8, rand_instr(), 4'($urandom), 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc %0d: got %h exp %h", i, pc, m_pc); end
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rand_flags %0d: got %h exp %h", i, flags, m_flags); end
      checks++;
      if ({flush, taken, halted} !== {m_flush_left > 0, m_taken, m_halted}) begin
        errors++; $display("FAIL rand_ctl %0d: got %b exp %b", i, {flush, taken, halted}, {m_flush_left > 0, m_taken, m_halted});
      end
    end
    checks++; if (br_total_cnt !== exp_total()) begin errors++; $display("FAIL rand_total: got %0d exp %0d", br_total_cnt, exp_total()); end
    checks++; if (br_taken_cnt !== exp_taken_n()) begin errors++; $display("FAIL rand_taken_cnt: got %0d exp %0d", br_taken_cnt, exp_taken_n()); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_branch_be();
    test_conditions();
    test_wrap_stall();
    test_halt();
    test_async_reset();
    test_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
